// File: rtl/temp_pkg.sv
// Shared types and constants for the BCD temperature digit-serial link.
package temp_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StSetup,
    StStrobe,
    StGap,
    StDone
  } tx_state_e;

  function automatic logic is_bcd(digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/temp_output.sv
// Digit-serial transmitter: latches a 3-digit BCD value and replays it as a start
// strobe followed by ones, tens and hundreds strobes on a 4-bit bus.
module temp_output
  import temp_pkg::*;
#(
  parameter int unsigned HOLD = 1,
  parameter int unsigned GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] huns,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic [3:0] value,
  output logic       enter,
  output logic       done,
  output logic       err
);

  localparam int unsigned CntMax = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLd = CntW'(HOLD - 1);
  localparam logic [CntW-1:0] GapLd  = CntW'(GAP - 1);
  localparam logic [1:0]      LastIdx = 2'(NUM_DIGITS - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            first_q, first_d;
  logic            err_q, err_d;
  logic            accept;
  digit_t          digits_q [NUM_DIGITS];
  digit_t          cur_digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      err_q   <= err_d;
      if (accept) begin
        digits_q[0] <= ones;
        digits_q[1] <= tens;
        digits_q[2] <= huns;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    first_d = first_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_bcd(huns) && is_bcd(tens) && is_bcd(ones)) begin
            accept  = 1'b1;
            idx_d   = '0;
            first_d = 1'b1;
            state_d = StStart;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StStart, StStrobe: begin
        cnt_d   = GapLd;
        state_d = StGap;
      end
      StSetup: begin
        if (cnt_q == '0) state_d = StStrobe;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (first_q) begin
          // Gap after the start-of-number strobe: first digit keeps index 0.
          first_d = 1'b0;
          cnt_d   = HoldLd;
          state_d = StSetup;
        end else if (idx_q < LastIdx) begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = HoldLd;
          state_d = StSetup;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (idx_q)
      2'd0:    cur_digit = digits_q[0];
      2'd1:    cur_digit = digits_q[1];
      default: cur_digit = digits_q[2];
    endcase
  end

  // Outputs decode straight from state so an async reset drops them without a clock.
  always_comb begin
    busy  = 1'b0;
    enter = 1'b0;
    done  = 1'b0;
    value = '0;
    unique case (state_q)
      StStart: begin
        busy  = 1'b1;
        enter = 1'b1;
      end
      StSetup: begin
        busy  = 1'b1;
        value = cur_digit;
      end
      StStrobe: begin
        busy  = 1'b1;
        enter = 1'b1;
        value = cur_digit;
      end
      StGap: begin
        busy  = 1'b1;
        value = first_q ? 4'd0 : cur_digit;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_temp_output.sv
// Randomized bench for temp_output: two parameterizations share stimulus and are
// compared cycle by cycle against a timeline model derived from the framing rules.
module tb_temp_output;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] huns = '0, tens = '0, ones = '0;

  logic       a_busy, a_enter, a_done, a_err;
  logic [3:0] a_value;
  logic       b_busy, b_enter, b_done, b_err;
  logic [3:0] b_value;

  int total = 0;
  int bad   = 0;

  temp_output #(.HOLD(1), .GAP(2)) u_a (
    .clk(clk), .rst(rst), .start(start), .huns(huns), .tens(tens), .ones(ones),
    .busy(a_busy), .value(a_value), .enter(a_enter), .done(a_done), .err(a_err)
  );

  temp_output #(.HOLD(3), .GAP(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .huns(huns), .tens(tens), .ones(ones),
    .busy(b_busy), .value(b_value), .enter(b_enter), .done(b_done), .err(b_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {busy, enter, done, err, value} in cycle t after the sampling edge.
  function automatic logic [7:0] model(input int hold, input int gap, input bit acc,
                                       input logic [3:0] d0, input logic [3:0] d1,
                                       input logic [3:0] d2, input int t);
    logic [3:0] dig [3];
    int len, r, k, p;
    dig[0] = d0;
    dig[1] = d1;
    dig[2] = d2;
    len = 1 + gap + 3 * (hold + 1 + gap);
    if (!acc) return {3'b000, (t == 1), 4'h0};
    if (t == 1) return 8'b1100_0000;
    if (t <= 1 + gap) return 8'b1000_0000;
    if (t <= len) begin
      r = t - 2 - gap;
      k = r / (hold + 1 + gap);
      p = r % (hold + 1 + gap);
      return {1'b1, (p == hold), 2'b00, dig[k]};
    end
    if (t == len + 1) return 8'b0010_0000;
    return 8'h00;
  endfunction

  // Runs one request; optionally pulses start with other digits mid-transaction and
  // optionally asserts reset in cycle rst_at (0 = never).
  task automatic run_txn(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input bit mid, input int rst_at);
    bit acc;
    int tp;
    acc = (h <= 9) && (t <= 9) && (o <= 9);
    tp  = (mid && acc) ? int'($urandom_range(2, 10)) : 0;
    @(negedge clk);
    huns  = h;
    tens  = t;
    ones  = o;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1 start = 1'b0;
      end
      check_eq($sformatf("a_c%0d", c), {a_busy, a_enter, a_done, a_err, a_value},
               model(1, 2, acc, o, t, h, c));
      check_eq($sformatf("b_c%0d", c), {b_busy, b_enter, b_done, b_err, b_value},
               model(3, 1, acc, o, t, h, c));
      if (c == tp) begin
        huns  = 4'($urandom_range(0, 9));
        tens  = 4'($urandom_range(0, 9));
        ones  = 4'($urandom_range(0, 9));
        start = 1'b1;
      end
      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1;
        check_eq("a_rst_now", {a_busy, a_enter, a_done, a_err, a_value}, 32'h0);
        check_eq("b_rst_now", {b_busy, b_enter, b_done, b_err, b_value}, 32'h0);
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          check_eq("a_rst_hold", {a_busy, a_enter, a_done, a_err, a_value}, 32'h0);
          check_eq("b_rst_hold", {b_busy, b_enter, b_done, b_err, b_value}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] h, t, o;
    #12;
    check_eq("a_reset", {a_busy, a_enter, a_done, a_err, a_value}, 32'h0);
    check_eq("b_reset", {b_busy, b_enter, b_done, b_err, b_value}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_txn(4'd1, 4'd2, 4'd3, 1'b0, 0);
    run_txn(4'd1, 4'hA, 4'd3, 1'b0, 0);
    run_txn(4'd8, 4'd7, 4'd5, 1'b1, 0);
    run_txn(4'd9, 4'd0, 4'd9, 1'b0, 7);
    run_txn(4'd4, 4'd4, 4'd0, 1'b0, 0);
    run_txn(4'd0, 4'd0, 4'hF, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      h = 4'($urandom_range(0, 9));
      t = 4'($urandom_range(0, 9));
      o = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       h = 4'($urandom_range(10, 15));
          1:       t = 4'($urandom_range(10, 15));
          default: o = 4'($urandom_range(10, 15));
        endcase
      end
      run_txn(h, t, o, bit'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
